// File: rtl/hyperram_op_scheduler_pkg.sv
// hyperram_op_scheduler_pkg: PHY opcodes, scheduler states and opcode lookup
package hyperram_op_scheduler_pkg;
  localparam logic [2:0] OP_HW_RST = 3'b000;
  localparam logic [2:0] OP_RD_REG = 3'b001;
  localparam logic [2:0] OP_WR_REG = 3'b010;
  localparam logic [2:0] OP_RD_MEM = 3'b011;
  localparam logic [2:0] OP_WR_MEM = 3'b100;
  typedef enum logic [2:0] {S_IDLE, S_RST, S_CFG, S_ID, S_GAP, S_READY, S_ISSUE, S_FAIL} state_t;
  function automatic logic [2:0] init_op(input state_t s);
    return s == S_CFG ? OP_WR_REG : s == S_ID ? OP_RD_REG : OP_HW_RST;
  endfunction
  function automatic logic is_init_op(input state_t s);
    return s == S_RST || s == S_CFG || s == S_ID;
  endfunction
endpackage

// File: rtl/hyperram_rr_arb2.sv
// hyperram_rr_arb2: 2-way round-robin arbiter, pointer remembers the last grantee
module hyperram_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);
  logic r_last_b;
  always_comb o_gnt = i_req == 2'b11 ? (r_last_b ? 2'b01 : 2'b10) : i_req;
  always_ff @(posedge i_clk)
    if (!i_rst_n) r_last_b <= 1'b1;
    else if (i_advance && |o_gnt) r_last_b <= o_gnt[1];
endmodule

// File: rtl/hyperram_op_scheduler.sv
// hyperram_op_scheduler: runs HyperRAM power-up, then shares the PHY op engine between two requesters
module hyperram_op_scheduler
  import hyperram_op_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 2,
  parameter int INIT_RETRY_MAX = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic       o_init_done,
  output logic       o_init_fail,
  output logic       o_busy,
  input  logic       i_req_a,
  input  logic       i_req_b,
  input  logic       i_op_a,
  input  logic       i_op_b,
  output logic       o_gnt_a,
  output logic       o_gnt_b,
  output logic       o_done_a,
  output logic       o_done_b,
  output logic       o_err,
  output logic       o_phy_en,
  output logic [2:0] o_phy_op_req,
  input  logic       i_phy_op_done,
  output logic       o_timeout
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GP_W = $clog2(GAP_CYCLES + 1);
  localparam int RT_W = $clog2(INIT_RETRY_MAX + 2);
  state_t            r_state, r_next;
  logic [WD_W-1:0]   r_wd;
  logic [GP_W-1:0]   r_gap;
  logic [RT_W-1:0]   r_retry;
  logic [1:0]        w_gnt;
  logic              w_wd_exp;
  assign w_wd_exp = r_wd == WD_W'(TIMEOUT_CYCLES - 1);
  assign o_busy = !(r_state inside {S_IDLE, S_READY, S_FAIL});
  hyperram_rr_arb2 u_arb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    ({i_req_b, i_req_a}),
    .i_advance(r_state == S_READY),
    .o_gnt    (w_gnt)
  );
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_next       <= S_IDLE;
      r_wd         <= '0;
      r_gap        <= '0;
      r_retry      <= '0;
      o_init_done  <= 1'b0;
      o_init_fail  <= 1'b0;
      o_gnt_a      <= 1'b0;
      o_gnt_b      <= 1'b0;
      o_done_a     <= 1'b0;
      o_done_b     <= 1'b0;
      o_err        <= 1'b0;
      o_phy_en     <= 1'b0;
      o_phy_op_req <= OP_HW_RST;
      o_timeout    <= 1'b0;
    end else begin
      o_done_a  <= 1'b0;
      o_done_b  <= 1'b0;
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
      case (r_state)
        S_IDLE, S_FAIL: if (i_start) begin
          r_state      <= S_RST;
          r_retry      <= '0;
          o_init_fail  <= 1'b0;
          o_init_done  <= 1'b0;
          o_phy_en     <= 1'b1;
          o_phy_op_req <= OP_HW_RST;
          r_wd         <= '0;
        end
        S_RST, S_CFG, S_ID, S_ISSUE: if (i_phy_op_done || w_wd_exp) begin
          r_state      <= S_GAP;
          r_gap        <= '0;
          o_phy_en     <= 1'b0;
          o_phy_op_req <= OP_HW_RST;
          if (r_state == S_ISSUE) begin
            o_done_a <= o_gnt_a;
            o_done_b <= o_gnt_b;
            o_err    <= !i_phy_op_done;
            r_next   <= S_READY;
          end else if (i_phy_op_done) begin
            r_next <= r_state == S_RST ? S_CFG : r_state == S_CFG ? S_ID : S_READY;
            if (r_state == S_ID) o_init_done <= 1'b1;
          end else begin
            r_retry <= r_retry + RT_W'(1);
            r_next  <= r_retry >= RT_W'(INIT_RETRY_MAX) ? S_FAIL : S_RST;
          end
          o_timeout <= !i_phy_op_done;
        end else r_wd <= r_wd + WD_W'(1);
        S_GAP: begin
          o_gnt_a <= 1'b0;
          o_gnt_b <= 1'b0;
          if (r_gap == GP_W'(GAP_CYCLES - 1)) begin
            r_state      <= r_next;
            o_phy_en     <= is_init_op(r_next);
            o_phy_op_req <= init_op(r_next);
            o_init_fail  <= r_next == S_FAIL;
            r_wd         <= '0;
          end else r_gap <= r_gap + GP_W'(1);
        end
        S_READY: if (|w_gnt) begin
          r_state      <= S_ISSUE;
          o_gnt_a      <= w_gnt[0];
          o_gnt_b      <= w_gnt[1];
          o_phy_en     <= 1'b1;
          o_phy_op_req <= (w_gnt[0] ? i_op_a : i_op_b) ? OP_WR_MEM : OP_RD_MEM;
          r_wd         <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hyperram_op_scheduler.sv
// tb_hyperram_op_scheduler: randomized scoreboard bench with a PHY responder and round-robin reference model
module tb_hyperram_op_scheduler;
  localparam int TO = 64;
  localparam int GP = 2;
  localparam int RM = 3;
  logic clk = 0, rst_n = 0, start = 0, req_a = 0, req_b = 0, op_a = 0, op_b = 0, phy_done = 0;
  logic init_done, init_fail, busy, gnt_a, gnt_b, done_a, done_b, err, phy_en, tmo;
  logic [2:0] phy_op;
  logic [12:0] outs;
  int checks = 0, failures = 0, cyc = 0, tmo_cnt = 0, phy_delay = 5;
  bit silent = 0;
  bit last_b = 1;
  logic [2:0] exp_op[$];
  logic [1:0] exp_done[$];
  assign outs = {init_done, init_fail, busy, gnt_a, gnt_b, done_a, done_b, err, phy_en, phy_op, tmo};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  hyperram_op_scheduler #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GP), .INIT_RETRY_MAX(RM)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_init_done(init_done), .o_init_fail(init_fail),
    .o_busy(busy), .i_req_a(req_a), .i_req_b(req_b), .i_op_a(op_a), .i_op_b(op_b),
    .o_gnt_a(gnt_a), .o_gnt_b(gnt_b), .o_done_a(done_a), .o_done_b(done_b), .o_err(err),
    .o_phy_en(phy_en), .o_phy_op_req(phy_op), .i_phy_op_done(phy_done), .o_timeout(tmo)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  task automatic expire(input string name);
    checks++;
    failures++;
    $display("FAIL %s wait expired", name);
  endtask
  // PHY responder: pulses done phy_delay cycles after enable unless silenced
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      phy_done = 0;
      if (phy_en && !silent) begin
        cnt++;
        if (cnt >= phy_delay) begin
          phy_done = 1;
          cnt = 0;
        end
      end else cnt = 0;
    end
  end
  initial begin
    logic prev_en = 0;
    logic [2:0] prev_op = 0;
    logic [1:0] e;
    int low = 100;
    forever begin
      @(negedge clk);
      if (phy_en && !prev_en) begin
        chk("phy_gap", low >= GP, 1);
        if (exp_op.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL phy_op unexpected actual=%0d", phy_op);
        end else chk("phy_op", phy_op, exp_op.pop_front());
      end
      if (phy_en && prev_en && phy_op !== prev_op) begin
        checks++;
        failures++;
        $display("FAIL phy_op_stable actual=%0d required=%0d", phy_op, prev_op);
      end
      low = phy_en ? 0 : low + 1;
      prev_en = phy_en;
      prev_op = phy_op;
      if (tmo) tmo_cnt++;
      if (done_a || done_b) begin
        if (exp_done.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done unexpected actual=%b%b", done_a, done_b);
        end else begin
          e = exp_done.pop_front();
          chk("done_pulse", {gnt_a, gnt_b, done_a, done_b, err, tmo}, {!e[1], e[1], !e[1], e[1], e[0], e[0]});
        end
      end
    end
  end
  initial begin
    #3ms;
    $display("FAIL global_time_limit");
    $fatal(1);
  end
  task automatic wait_ready(input string name);
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = init_done && !busy;
    end
    if (!ok) expire(name);
  endtask
  task automatic do_req(input bit who, input bit op);
    bit ok = 0;
    if (who) begin req_b = 1; op_b = op; end
    else begin req_a = 1; op_a = op; end
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = who ? done_b : done_a;
    end
    if (!ok) expire("req_done");
    if (who) req_b = 0;
    else req_a = 0;
    @(negedge clk);
  endtask
  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask
  task automatic push_init();
    exp_op.push_back(3'b000);
    exp_op.push_back(3'b010);
    exp_op.push_back(3'b001);
  endtask
  initial begin
    int g, t0, pat;
    bit oa, ob, first, ok;
    bit ra[2], rb[2];
    int ia, ib;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", outs, 0);
    @(negedge clk) rst_n = 1;
    push_init();
    pulse_start();
    wait_ready("init");
    chk("init_state", {init_done, init_fail, busy}, 3'b100);
    exp_op.push_back(3'b100);
    exp_done.push_back(2'b00);
    phy_delay = 20;
    req_a = 1;
    op_a = 1;
    @(posedge clk);
    #1 chk("grant_same_edge", {gnt_a, gnt_b, phy_en, phy_op}, {3'b101, 3'b100});
    last_b = 0;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = done_a;
    end
    if (!ok) expire("write_a_done");
    req_a = 0;
    wait_ready("after_write");
    silent = 1;
    exp_op.push_back(3'b011);
    exp_done.push_back(2'b11);
    req_b = 1;
    op_b = 0;
    @(posedge clk);
    #1 g = cyc;
    chk("grant_b", {gnt_a, gnt_b, phy_op}, {2'b01, 3'b011});
    last_b = 1;
    ok = 0;
    for (int i = 0; i < TO + 20 && !ok; i++) begin
      @(negedge clk);
      ok = done_b;
    end
    if (!ok) expire("timeout_done");
    chk("timeout_latency", cyc - g, TO);
    req_b = 0;
    silent = 0;
    wait_ready("ready_after_timeout");
    chk("ready_after_timeout", {init_done, busy, phy_en}, 3'b100);
    for (int r = 0; r < 10; r++) begin
      wait_ready("round");
      phy_delay = $urandom_range(1, 12);
      pat = $urandom_range(1, 3);
      oa = 1'($urandom);
      ob = 1'($urandom);
      if (pat == 3) begin
        first = !last_b;
        exp_op.push_back((first ? ob : oa) ? 3'b100 : 3'b011);
        exp_done.push_back({first, 1'b0});
        exp_op.push_back((first ? oa : ob) ? 3'b100 : 3'b011);
        exp_done.push_back({!first, 1'b0});
        last_b = !first;
        fork
          do_req(0, oa);
          do_req(1, ob);
        join
      end else begin
        first = pat == 2;
        exp_op.push_back((first ? ob : oa) ? 3'b100 : 3'b011);
        exp_done.push_back({first, 1'b0});
        last_b = first;
        do_req(first, first ? ob : oa);
      end
    end
    wait_ready("before_init_fail");
    @(negedge clk) rst_n = 0;
    @(negedge clk) rst_n = 1;
    last_b = 1;
    silent = 1;
    repeat (RM + 1) exp_op.push_back(3'b000);
    t0 = tmo_cnt;
    pulse_start();
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = init_fail;
    end
    if (!ok) expire("init_fail");
    chk("init_fail_state", {init_done, init_fail, busy, phy_en}, 4'b0100);
    chk("init_attempts", tmo_cnt - t0, RM + 1);
    silent = 0;
    phy_delay = 5;
    push_init();
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 chk("restart_from_fail", {init_fail, phy_en, phy_op}, 5'b01000);
    @(negedge clk) start = 0;
    wait_ready("reinit");
    chk("reinit_done", {init_done, init_fail}, 2'b10);
    silent = 1;
    exp_op.push_back(3'b100);
    req_a = 1;
    op_a = 1;
    @(posedge clk);
    #1 chk("grant_before_reset", {gnt_a, phy_en}, 2'b11);
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(posedge clk);
    #1 chk("reset_mid_op", outs, 0);
    @(negedge clk);
    rst_n = 1;
    req_a = 0;
    silent = 0;
    last_b = 1;
    repeat (10) @(negedge clk);
    chk("no_autostart", {phy_en, init_done, busy}, 3'b000);
    push_init();
    pulse_start();
    wait_ready("init_after_reset");
    for (int k = 0; k < 2; k++) begin
      ra[k] = 1'($urandom);
      rb[k] = 1'($urandom);
    end
    ia = 0;
    ib = 0;
    for (int k = 0; k < 4; k++) begin
      first = !last_b;
      exp_op.push_back((first ? rb[ib] : ra[ia]) ? 3'b100 : 3'b011);
      exp_done.push_back({first, 1'b0});
      if (first) ib++;
      else ia++;
      last_b = first;
    end
    phy_delay = 4;
    fork
      begin do_req(0, ra[0]); do_req(0, ra[1]); end
      begin do_req(1, rb[0]); do_req(1, rb[1]); end
    join
    repeat (6) @(negedge clk);
    chk("phy_ops_drained", exp_op.size(), 0);
    chk("dones_drained", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
